// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from the upstream FIFO and shifts them out as 8N1 UART frames.
// Define UARTTX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       UARTTX_RST,
    input  logic       UARTTX_Enable,
    input  logic       UARTTX_FIFO_EMPTY,
    input  logic [7:0] UARTTX_FIFO_Data,
    output logic       UARTTX_FIFO_RD,
    output logic       UARTTX_TXD,
    output logic       UARTTX_BUSY,
    output logic       UARTTX_DONE
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t        r_state, w_state_nxt, w_after_data;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_shift;
    logic          w_tick, w_txd_nxt, w_rd_nxt, w_busy_nxt, w_done_nxt;

`ifdef UARTTX_PARITY_EN
    assign w_after_data = S_PARITY;
`else
    assign w_after_data = S_STOP;
`endif

    assign w_tick = (r_timer == LAST);

    always_ff @(posedge CLK or posedge UARTTX_RST) begin
        if (UARTTX_RST) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_idx   <= w_idx_nxt;
            if (r_state == S_LOAD)
                r_shift <= UARTTX_FIFO_Data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (UARTTX_Enable && !UARTTX_FIFO_EMPTY) w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_START;
            S_START:  if (w_tick) w_state_nxt = S_DATA;
            S_DATA:   if (w_tick && r_idx == 3'd7) w_state_nxt = w_after_data;
`ifdef UARTTX_PARITY_EN
            S_PARITY: if (w_tick) w_state_nxt = S_STOP;
`endif
            S_STOP:   if (w_tick) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        w_timer_nxt = (w_state_nxt != r_state || w_tick || r_state == S_IDLE) ? '0 : r_timer + TW'(1);
        w_idx_nxt   = (r_state == S_DATA && w_tick) ? r_idx + 3'd1 : r_idx;
    end

    // Outputs are precomputed from the next state so the registered pins line up with the state.
    always_comb begin
        w_rd_nxt   = (w_state_nxt == S_FETCH);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_STOP) && (w_timer_nxt == LAST);
        w_txd_nxt  = (w_state_nxt == S_START)  ? 1'b0 :
                     (w_state_nxt == S_DATA)   ? r_shift[w_idx_nxt] :
                     (w_state_nxt == S_PARITY) ? ^r_shift : 1'b1;
    end

    always_ff @(posedge CLK or posedge UARTTX_RST) begin
        if (UARTTX_RST) begin
            UARTTX_FIFO_RD <= 1'b0;
            UARTTX_TXD     <= 1'b1;
            UARTTX_BUSY    <= 1'b0;
            UARTTX_DONE    <= 1'b0;
        end else begin
            UARTTX_FIFO_RD <= w_rd_nxt;
            UARTTX_TXD     <= w_txd_nxt;
            UARTTX_BUSY    <= w_busy_nxt;
            UARTTX_DONE    <= w_done_nxt;
        end
    end
endmodule
